// File: rtl/calc_arbiter.sv
// Round-robin arbiter that shares one go/done calculator between NREQ requesters.
// Optional WAIT timeout with tmo_err output is enabled by defining CALC_ARB_TIMEOUT_EN.
module calc_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 3,
    parameter int TMO  = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_in1,
    input  logic [NREQ*W-1:0] req_in2,
    input  logic [2*NREQ-1:0] req_op,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_data,
    output logic              busy,
    output logic [W-1:0]      calc_in1,
    output logic [W-1:0]      calc_in2,
    output logic [1:0]        calc_op,
    output logic              calc_go,
    input  logic              calc_done,
`ifdef CALC_ARB_TIMEOUT_EN
    input  logic [W-1:0]      calc_out,
    output logic              tmo_err
`else
    input  logic [W-1:0]      calc_out
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, idx_q, win_idx;
    logic            win_found;
    logic [NREQ-1:0] gnt_q;
    logic [W-1:0]    in1_q, in2_q, rsp_data_q;
    logic [1:0]      op_q;
    logic            tmo_hit;

    // First requesting index at or after ptr_q, wrapping around.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr_q) + i) % NREQ;
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = IW'(j);
            end
        end
    end

`ifdef CALC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] tmo_cnt_q;
    logic          tmo_flag_q;

    assign tmo_hit = (state_q == StWait) && !calc_done && (tmo_cnt_q == CW'(TMO - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == StWait) ? tmo_cnt_q + 1'b1 : '0;
            if (tmo_hit) begin
                tmo_flag_q <= 1'b1;
            end else if (state_q == StResp) begin
                tmo_flag_q <= 1'b0;
            end
        end
    end

    assign tmo_err = (state_q == StResp) && tmo_flag_q;
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (win_found) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (calc_done || tmo_hit) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            idx_q      <= '0;
            gnt_q      <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            op_q       <= '0;
            rsp_data_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_found) begin
                        idx_q <= win_idx;
                        gnt_q <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                        in1_q <= req_in1[win_idx*W +: W];
                        in2_q <= req_in2[win_idx*W +: W];
                        op_q  <= req_op[win_idx*2 +: 2];
                    end
                end
                StWait: begin
                    if (calc_done) begin
                        rsp_data_q <= calc_out;
                    end else if (tmo_hit) begin
                        rsp_data_q <= '0;
                    end
                end
                StResp: begin
                    gnt_q <= '0;
                    ptr_q <= (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != StIdle);
        calc_go   = (state_q == StIssue) || (state_q == StWait);
        rsp_valid = (state_q == StResp) ? gnt_q : '0;
        gnt       = gnt_q;
        calc_in1  = in1_q;
        calc_in2  = in2_q;
        calc_op   = op_q;
        rsp_data  = rsp_data_q;
    end

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed self-checking bench for calc_arbiter with a simple go/done calculator model.
module tb_calc_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req;
    logic [11:0]     req_in1, req_in2;
    logic [7:0]      req_op;
    logic [3:0]      gnt, rsp_valid;
    logic [2:0]      rsp_data, calc_in1, calc_in2, calc_out;
    logic [1:0]      calc_op;
    logic            busy, calc_go, calc_done;
`ifdef CALC_ARB_TIMEOUT_EN
    logic            tmo_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] go_cnt;
    logic [7:0] done_dly;

    always #5 clk = ~clk;

    calc_arbiter #(.NREQ(NREQ), .W(W), .TMO(31)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .req_op    (req_op),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .calc_in1  (calc_in1),
        .calc_in2  (calc_in2),
        .calc_op   (calc_op),
        .calc_go   (calc_go),
        .calc_done (calc_done),
`ifdef CALC_ARB_TIMEOUT_EN
        .calc_out  (calc_out),
        .tmo_err   (tmo_err)
`else
        .calc_out  (calc_out)
`endif
    );

    // Calculator model: done after go has been high for done_dly cycles.
    always @(posedge clk) begin
        if (!calc_go) go_cnt <= 8'd0;
        else          go_cnt <= go_cnt + 8'd1;
    end
    assign calc_done = calc_go && (go_cnt == done_dly);

    always_comb begin
        case (calc_op)
            2'b00:   calc_out = calc_in1 + calc_in2;
            2'b01:   calc_out = calc_in1 - calc_in2;
            2'b10:   calc_out = calc_in1 & calc_in2;
            default: calc_out = calc_in1 ^ calc_in2;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] a, input logic [2:0] b,
                           input logic [1:0] op);
        req_in1[i*3 +: 3] = a;
        req_in2[i*3 +: 3] = b;
        req_op[i*2 +: 2]  = op;
    endtask

    // Tick until a response strobe appears; returns the strobe and data.
    task automatic wait_rsp(output logic [3:0] vld, output logic [2:0] data);
        int n;
        n = 0;
        vld = 4'd0;
        data = 3'd0;
        while (n < 60 && vld == 4'd0) begin
            tick();
            n++;
            vld  = rsp_valid;
            data = rsp_data;
        end
        if (vld == 4'd0) check("rsp_timeout", 32'd0, 32'd1);
        check("rsp_onehot", 32'($countones(vld)), 32'd1);
    endtask

    logic [3:0] v;
    logic [2:0] d;
    logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [2:0] exp_data  [5] = '{3'd2, 3'd7, 3'd2, 3'd6, 3'd2};
    int         seen;

    initial begin
        rst = 1'b1; req = '0; req_in1 = '0; req_in2 = '0; req_op = '0; done_dly = 8'd2;
        tick(); tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_go", 32'(calc_go), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        rst = 1'b0;
        tick();

        // 1: single add 3+2
        set_req(0, 3'd3, 3'd2, 2'b00);
        req = 4'b0001;
        tick();
        check("t1_issue_gnt", 32'(gnt), 32'b0001);
        check("t1_issue_go", 32'(calc_go), 32'd1);
        check("t1_issue_in1", 32'(calc_in1), 32'd3);
        tick();
        check("t1_wait_go", 32'(calc_go), 32'd1);
        check("t1_wait_vld", 32'(rsp_valid), 32'd0);
        tick();
        check("t1_wait2_vld", 32'(rsp_valid), 32'd0);
        tick();
        check("t1_rsp_vld", 32'(rsp_valid), 32'b0001);
        check("t1_rsp_data", 32'(rsp_data), 32'd5);
        check("t1_rsp_go", 32'(calc_go), 32'd0);
        req = 4'b0000;
        tick();
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_vld", 32'(rsp_valid), 32'd0);
        check("t1_hold_data", 32'(rsp_data), 32'd5);

        // 2: round robin with all requesters held (ptr now 1, so restart with a reset)
        rst = 1'b1; tick(); rst = 1'b0;
        done_dly = 8'd1;
        set_req(0, 3'd1, 3'd1, 2'b00);
        set_req(1, 3'd6, 3'd7, 2'b01);
        set_req(2, 3'd6, 3'd3, 2'b10);
        set_req(3, 3'd5, 3'd3, 2'b11);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(v, d);
            check($sformatf("t2_gnt%0d", k), 32'(v), 32'(exp_order[k]));
            check($sformatf("t2_data%0d", k), 32'(d), 32'(exp_data[k]));
        end
        req = 4'b0000;
        tick(); tick();
        check("t2_idle", 32'(busy), 32'd0);

        // 3: operands latched at grant; req dropped after grant still completes
        done_dly = 8'd3;
        set_req(2, 3'd4, 3'd1, 2'b01);
        req = 4'b0100;
        tick(); tick();
        req_in1[6 +: 3] = 3'd7;
        req = 4'b0000;
        wait_rsp(v, d);
        check("t3_gnt", 32'(v), 32'b0100);
        check("t3_data", 32'(d), 32'd3);

        // 4: reset during WAIT drops the transaction and restarts the pointer
        done_dly = 8'd10;
        set_req(3, 3'd1, 3'd1, 2'b00);
        req = 4'b1000;
        tick(); tick();
        check("t4_in_wait", 32'(calc_go), 32'd1);
        rst = 1'b1;
        #1;
        check("t4_rst_gnt", 32'(gnt), 32'd0);
        check("t4_rst_go", 32'(calc_go), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_in1", 32'(calc_in1), 32'd0);
        check("t4_rst_data", 32'(rsp_data), 32'd0);
        req = 4'b0000;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (rsp_valid != 4'd0) seen++;
        end
        check("t4_no_rsp", 32'(seen), 32'd0);
        done_dly = 8'd1;
        set_req(1, 3'd2, 3'd2, 2'b00);
        req = 4'b1010;
        wait_rsp(v, d);
        check("t4_gnt", 32'(v), 32'b0010);
        check("t4_data", 32'(d), 32'd4);
        req = 4'b0000;
        tick(); tick();

        // 5: served requester drops to lowest priority
        rst = 1'b1; tick(); rst = 1'b0;
        set_req(0, 3'd1, 3'd2, 2'b00);
        set_req(3, 3'd7, 3'd5, 2'b10);
        req = 4'b1001;
        wait_rsp(v, d);
        check("t5_first_gnt", 32'(v), 32'b0001);
        check("t5_first_data", 32'(d), 32'd3);
        wait_rsp(v, d);
        check("t5_second_gnt", 32'(v), 32'b1000);
        check("t5_second_data", 32'(d), 32'd5);
        req = 4'b0000;
        tick(); tick();

`ifdef CALC_ARB_TIMEOUT_EN
        // 6: done never arrives; 31 WAIT cycles then timeout response
        done_dly = 8'd255;
        set_req(1, 3'd3, 3'd3, 2'b00);
        req = 4'b0011;
        tick();
        check("t6_issue_gnt", 32'(gnt), 32'b0001);
        seen = 0;
        while (seen < 60 && rsp_valid == 4'd0) begin
            tick();
            seen++;
        end
        check("t6_wait_len", 32'(seen), 32'd32);
        check("t6_vld", 32'(rsp_valid), 32'b0001);
        check("t6_tmo_err", 32'(tmo_err), 32'd1);
        check("t6_data", 32'(rsp_data), 32'd0);
        check("t6_go", 32'(calc_go), 32'd0);
        req = 4'b0010;
        done_dly = 8'd1;
        wait_rsp(v, d);
        check("t6_next_gnt", 32'(v), 32'b0010);
        check("t6_next_data", 32'(d), 32'd6);
        check("t6_next_tmo", 32'(tmo_err), 32'd0);
        req = 4'b0000;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
